bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bcd_pkg.sv | 6 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bin_to_bcd_seq.sv | 89 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM encoding and digit constants for the sequential binary-to-BCD converter
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcdState_e;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble add-3 adjust for one BCD digit
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digIn,
  output logic [BCD_DIGIT_W-1:0] digOut
);
  assign digOut = (digIn >= BCD_DIGIT_W'(ADD3_THRESH)) ? digIn + BCD_DIGIT_W'(3) : digIn;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Define BCD_SIGNED_EN to treat binIn as two's complement (magnitude converted, signOut flags negatives).
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [IN_W-1:0]               binIn,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcdOut,
  output logic                          ovf,
  output logic                          signOut
);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  bcdState_e state, stateNext;
  logic [IN_W-1:0] binReg, binLoad;
  logic [BCD_W-1:0] bcdReg, bcdAdj, bcdNext;
  logic [CNT_W-1:0] cnt;
  logic negIn, load, lastStep, ovfNext;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digIn (bcdReg[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digOut(bcdAdj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
`ifdef BCD_SIGNED_EN
  assign negIn = binIn[IN_W-1];
`else
  assign negIn = 1'b0;
`endif
  // unsigned negation of the most negative value yields 2^(IN_W-1), which is exactly its magnitude
  assign binLoad  = negIn ? -binIn : binIn;
  assign bcdNext  = {bcdAdj[BCD_W-2:0], binReg[IN_W-1]};
  assign load     = start && state != SHIFT;
  assign lastStep = state == SHIFT && cnt == CNT_W'(1);
  assign busy     = state == SHIFT;
  assign done     = state == DONE;
  always_comb begin
    ovfNext = 1'b0;
    for (int k = 4; k < DIGITS; k++) ovfNext = ovfNext | (|bcdNext[k*BCD_DIGIT_W +: BCD_DIGIT_W]);
    stateNext = (state == SHIFT) ? (lastStep ? DONE : SHIFT) : (start ? SHIFT : IDLE);
  end
  // results are captured on the final step so they are already valid while done is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      binReg <= '0;
      bcdReg <= '0;
      cnt    <= '0;
      bcdOut <= '0;
      ovf    <= 1'b0;
    end else begin
      state <= stateNext;
      if (load) begin
        binReg <= binLoad;
        bcdReg <= '0;
        cnt    <= CNT_W'(IN_W);
      end else if (state == SHIFT) begin
        binReg <= binReg << 1;
        bcdReg <= bcdNext;
        cnt    <= cnt - CNT_W'(1);
        if (lastStep) begin
          bcdOut <= bcdNext;
          ovf    <= ovfNext;
        end
      end
    end
  end
`ifdef BCD_SIGNED_EN
  logic signReg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signReg <= 1'b0;
      signOut <= 1'b0;
    end else begin
      if (load) signReg <= negIn;
      if (lastStep) signOut <= signReg;
    end
  end
`else
  assign signOut = 1'b0;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq; directed vectors, monitor pops on each done pulse.
module tb_bin_to_bcd_seq;
  localparam int IN_W = 16;
  localparam int DIGITS = 5;
  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
    logic        sgn;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst, start;
  logic [IN_W-1:0] binIn;
  logic busy, done, ovf, signOut;
  logic [4*DIGITS-1:0] bcdOut;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .binIn(binIn),
    .busy(busy), .done(done), .bcdOut(bcdOut), .ovf(ovf), .signOut(signOut)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bcdOut", 32'(bcdOut), 32'(e.bcd));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("signOut", 32'(signOut), 32'(e.sgn));
        chk("done cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end
  task automatic push(input logic [19:0] b, input logic o, input logic s, input int c);
    exp_t e;
    e.bcd = b; e.ovf = o; e.sgn = s; e.cyc = c;
    sb.push_back(e);
  endtask
  task automatic waitDone();
    bool_loop: begin
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (done) begin
          chk("busy in DONE", 32'(busy), 32'd0);
          disable bool_loop;
        end
      end
      chk("done timeout", 32'd1, 32'd0);
    end
  endtask
  task automatic convert(input logic [IN_W-1:0] v, input logic [19:0] b, input logic o, input logic s);
    @(posedge clk);
    #1 binIn = v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    push(b, o, s, cyc + IN_W);
    @(negedge clk);
    chk("busy in SHIFT", 32'(busy), 32'd1);
    waitDone();
  endtask
  initial begin
    int t0;
    rst = 1'b1;
    start = 1'b1;
    binIn = 16'd1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset bcdOut", 32'(bcdOut), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset signOut", 32'(signOut), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle after reset", 32'(busy), 32'd0);
    convert(16'd0, 20'h00000, 1'b0, 1'b0);
    convert(16'd9999, 20'h09999, 1'b0, 1'b0);
    convert(16'd10000, 20'h10000, 1'b1, 1'b0);
    convert(16'd1, 20'h00001, 1'b0, 1'b0);
    convert(16'd12345, 20'h12345, 1'b1, 1'b0);
`ifdef BCD_SIGNED_EN
    convert(16'hFFFF, 20'h00001, 1'b0, 1'b1);
    convert(16'h8000, 20'h32768, 1'b1, 1'b1);
    convert(16'h7FFF, 20'h32767, 1'b1, 1'b0);
    convert(16'hD8F1, 20'h09999, 1'b0, 1'b1);
`else
    convert(16'd65535, 20'h65535, 1'b1, 1'b0);
    convert(16'h8000, 20'h32768, 1'b1, 1'b0);
`endif
    // second start mid-conversion must be ignored
    @(posedge clk);
    #1 binIn = 16'd4321;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    push(20'h04321, 1'b0, 1'b0, cyc + IN_W);
    repeat (4) @(posedge clk);
    #1 binIn = 16'd777;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone();
    repeat (10) @(negedge clk);
    chk("result held", 32'(bcdOut), 32'h04321);
    chk("ignored start idle", 32'(busy), 32'd0);
    // reset during SHIFT cycle 8 discards the conversion
    @(posedge clk);
    #1 binIn = 16'd5555;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst bcdOut", 32'(bcdOut), 32'd0);
    chk("mid-rst done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post-rst bcdOut", 32'(bcdOut), 32'd0);
    // start held high: one result every IN_W+1 cycles
    @(posedge clk);
    #1 binIn = 16'd100;
    start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    push(20'h00100, 1'b0, 1'b0, t0 + IN_W);
    binIn = 16'd2000;
    repeat (IN_W + 1) @(posedge clk);
    #1 push(20'h02000, 1'b0, 1'b0, t0 + 2 * IN_W + 1);
    binIn = 16'd30000;
    repeat (IN_W + 1) @(posedge clk);
    #1 push(20'h30000, 1'b1, 1'b0, t0 + 3 * IN_W + 2);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("held start idle", 32'(busy), 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
